// File: rtl/scm_bist_pkg.sv
// Shared types and the March C- element table for the SCM BIST controller.
package scm_bist_pkg;

    localparam int unsigned NUM_ELEM   = 6;
    localparam int unsigned ELEM_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [ELEM_WIDTH-1:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_e;

    typedef enum logic {
        PH_RD = 1'b0,
        PH_WR = 1'b1
    } phase_e;

    // One march element: address direction, optional read with its expected
    // bit value, optional write with its data bit value.
    typedef struct packed {
        logic up;
        logic has_rd;
        logic rd_val;
        logic has_wr;
        logic wr_val;
    } march_step_t;

    // M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 up r0
    localparam march_step_t MARCH_TABLE [NUM_ELEM] = '{
        '{up: 1'b1, has_rd: 1'b0, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b0},
        '{up: 1'b1, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1},
        '{up: 1'b1, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0},
        '{up: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1},
        '{up: 1'b0, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0},
        '{up: 1'b1, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b0, wr_val: 1'b0}
    };

endpackage

// File: rtl/scm_bist_addr_gen.sv
// Up/down address counter with synchronous load and a last-address flag.
module scm_bist_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_c
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    // Counter register: load has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (en) begin
            addr <= up ? addr + ADDR_WIDTH'(1) : addr - ADDR_WIDTH'(1);
        end
    end

    // Last address of the current sweep direction.
    assign last_c = up ? (addr == ADDR_MAX) : (addr == '0);

endmodule

// File: rtl/scm_bist_ctrl.sv
// March C- BIST controller driving the test port of a standard-cell memory.
module scm_bist_ctrl
    import scm_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    state_e                  state_q, state_d;
    elem_e                   elem_q, elem_d, elem_nxt;
    phase_e                  phase_q, phase_d;

    logic                    ag_load, ag_en, ag_last_c;
    logic [ADDR_WIDTH-1:0]   ag_load_val, ag_addr;

    logic                    rd_pend_q, rd_exp_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [2:0]              rd_elem_q;

    logic                    mismatch_c, accept_c, wr_d, busy_d;

    logic                    busy_q, done_q, fail_q;
    logic [ADDR_WIDTH-1:0]   fail_addr_q;
    logic [2:0]              fail_elem_q;
    logic                    csn_q, wen_q;
    logic [DATA_WIDTH-1:0]   d_q;
    logic [NUM_BYTE-1:0]     be_q;

    scm_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (ag_load),
        .load_val (ag_load_val),
        .en       (ag_en),
        .up       (MARCH_TABLE[elem_q].up),
        .addr     (ag_addr),
        .last_c   (ag_last_c)
    );

    // Next-state, address-generator control and next registered outputs.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        ag_load     = 1'b1;
        ag_load_val = '0;
        ag_en       = 1'b0;
        accept_c    = 1'b0;
        elem_nxt    = (elem_q == M5) ? M5 : elem_e'(3'(elem_q) + 3'd1);
        mismatch_c  = rd_pend_q && ((state_q == ST_RUN) || (state_q == ST_FLUSH)) &&
                      (Q_T != {DATA_WIDTH{rd_exp_q}});

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = ST_RUN;
                    elem_d   = M0;
                    phase_d  = MARCH_TABLE[M0].has_rd ? PH_RD : PH_WR;
                end
            end
            ST_RUN: begin
                if (mismatch_c) begin
                    state_d = ST_DONE;
                end else if ((phase_q == PH_RD) && MARCH_TABLE[elem_q].has_wr) begin
                    // Read-then-write pair stays on the same address.
                    phase_d = PH_WR;
                    ag_load = 1'b0;
                end else if (!ag_last_c) begin
                    ag_load = 1'b0;
                    ag_en   = 1'b1;
                    phase_d = MARCH_TABLE[elem_q].has_rd ? PH_RD : PH_WR;
                end else if (elem_q == M5) begin
                    state_d = ST_FLUSH;
                end else begin
                    // Wrap straight into the next element's start address.
                    elem_d      = elem_nxt;
                    phase_d     = MARCH_TABLE[elem_nxt].has_rd ? PH_RD : PH_WR;
                    ag_load_val = MARCH_TABLE[elem_nxt].up ? '0 : '1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_d   = (state_d == ST_RUN) && (phase_d == PH_WR);
        busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    // State, pending-read tracking, status and test-port output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= M0;
            phase_q     <= PH_RD;
            rd_pend_q   <= 1'b0;
            rd_exp_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_elem_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            d_q         <= '0;
            be_q        <= '0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            phase_q   <= phase_d;
            rd_pend_q <= (state_q == ST_RUN) && (phase_q == PH_RD);
            rd_exp_q  <= MARCH_TABLE[elem_q].rd_val;
            rd_addr_q <= ag_addr;
            rd_elem_q <= 3'(elem_q);
            busy_q    <= busy_d;
            done_q    <= (state_d == ST_DONE);
            csn_q     <= (state_d != ST_RUN);
            wen_q     <= !wr_d;
            d_q       <= wr_d ? {DATA_WIDTH{MARCH_TABLE[elem_d].wr_val}} : '0;
            be_q      <= wr_d ? '1 : '0;
            if (accept_c) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= '0;
            end else if (mismatch_c) begin
                fail_q      <= 1'b1;
                fail_addr_q <= rd_addr_q;
                fail_elem_q <= rd_elem_q;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign BIST      = busy_q;
    assign CSN_T     = csn_q;
    assign WEN_T     = wen_q;
    assign A_T       = ag_addr;
    assign D_T       = d_q;
    assign BE_T      = be_q;

endmodule

// File: tb/tb_scm_bist_ctrl.sv
// Self-checking bench for scm_bist_ctrl with a 1-cycle-read SCM model.
module tb_scm_bist_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned N  = 32;

    typedef struct packed {
        logic          bist;
        logic          csn;
        logic          wen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NB-1:0] be;
    } acc_t;

    localparam bit DIR_UP [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam bit HAS_RD [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam bit HAS_WR [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit WR_V   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic          clk = 1'b0;
    logic          rst, start;
    logic          busy, done, fail, BIST, CSN_T, WEN_T;
    logic [AW-1:0] fail_addr, A_T;
    logic [2:0]    fail_elem;
    logic [DW-1:0] D_T;
    logic [NB-1:0] BE_T;
    logic [DW-1:0] Q_T = '0;

    logic [DW-1:0] mem [N];
    logic          fault_en = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    logic [DW-1:0] sa0_mask = '0;
    logic [DW-1:0] sa1_mask = '0;

    int checks = 0;
    int errors = 0;

    acc_t exp_q   [$];
    acc_t obs_q   [$];
    acc_t trace_q [$];
    acc_t post_acc;
    logic post_busy;
    logic first_done, first_fail;
    logic [AW-1:0] first_faddr;
    logic [2:0]    first_felem;
    acc_t idle_acc;

    scm_bist_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_BYTE   (NB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .BIST      (BIST),
        .CSN_T     (CSN_T),
        .WEN_T     (WEN_T),
        .A_T       (A_T),
        .D_T       (D_T),
        .BE_T      (BE_T),
        .Q_T       (Q_T)
    );

    always #5 clk = ~clk;

    // Behavioural 1r1w SCM: byte-enabled write, registered read, optional stuck bits.
    always @(posedge clk) begin
        if (!CSN_T && !WEN_T) begin
            for (int b = 0; b < NB; b++)
                if (BE_T[b]) mem[A_T][8*b +: 8] <= D_T[8*b +: 8];
        end
        if (!CSN_T && WEN_T) begin
            if (fault_en && (A_T == fault_addr)) Q_T <= (mem[A_T] & ~sa0_mask) | sa1_mask;
            else                                 Q_T <= mem[A_T];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic acc_t snap();
        acc_t s;
        s.bist = BIST; s.csn = CSN_T; s.wen = WEN_T;
        s.a = A_T; s.d = D_T; s.be = BE_T;
        return s;
    endfunction

    // Scoreboard fill: expected test-port activity for one full March C- run.
    task automatic build_expected();
        acc_t x;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < int'(N); i++) begin
                x.bist = 1'b1; x.csn = 1'b0;
                x.a    = DIR_UP[e] ? AW'(i) : AW'(int'(N) - 1 - i);
                if (HAS_RD[e]) begin
                    x.wen = 1'b1; x.d = '0; x.be = '0;
                    exp_q.push_back(x);
                end
                if (HAS_WR[e]) begin
                    x.wen = 1'b0; x.d = {DW{WR_V[e]}}; x.be = '1;
                    exp_q.push_back(x);
                end
            end
        end
        x.bist = 1'b1; x.csn = 1'b1; x.wen = 1'b1; x.a = '0; x.d = '0; x.be = '0;
        exp_q.push_back(x);
    endtask

    // Pulses start, records every busy cycle, optional extra start / reset mid-run.
    task automatic run_march(input int pulse_at, input int rst_at, output int nbusy);
        obs_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        first_done  = done;
        first_fail  = fail;
        first_faddr = fail_addr;
        first_felem = fail_elem;
        nbusy = 0;
        while ((busy === 1'b1) && (nbusy < 2000)) begin
            obs_q.push_back(snap());
            start = (nbusy == pulse_at);
            if (nbusy == rst_at) rst = 1'b1;
            nbusy++;
            tick();
        end
        start     = 1'b0;
        post_acc  = snap();
        post_busy = busy;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", fail); end
        checks++; if (fail_addr !== '0 || fail_elem !== '0) begin
            errors++; $display("FAIL reset_fail_info: got addr %0d elem %0d expected 0 0", fail_addr, fail_elem);
        end
        checks++; if (snap() !== idle_acc) begin
            errors++; $display("FAIL reset_ports: got %h expected %h", snap(), idle_acc);
        end
    endtask

    task automatic test_fault_free();
        int nb; acc_t ex;
        fault_en = 1'b0;
        build_expected();
        run_march(-1, -1, nb);
        for (int k = 0; k < obs_q.size(); k++) begin
            ex = exp_q.pop_front();
            checks++;
            if (obs_q[k] !== ex) begin errors++; $display("FAIL ff_access[%0d]: got %h expected %h", k, obs_q[k], ex); end
        end
        checks++; if (nb != 10 * int'(N) + 1) begin errors++; $display("FAIL ff_busy_cycles: got %0d expected %0d", nb, 10 * N + 1); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ff_done: got %b expected 1", done); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL ff_fail: got %b expected 0", fail); end
        checks++; if (post_acc !== idle_acc) begin errors++; $display("FAIL ff_idle_ports: got %h expected %h", post_acc, idle_acc); end
        trace_q = obs_q;
    endtask

    task automatic test_m3_trace();
        checks++;
        if (trace_q.size() < 225) begin
            errors++; $display("FAIL m3_trace_len: got %0d expected at least 225", trace_q.size());
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                checks++;
                if (trace_q[160 + 2*i].a !== AW'(int'(N) - 1 - i) || trace_q[161 + 2*i].a !== AW'(int'(N) - 1 - i)) begin
                    errors++; $display("FAIL m3_addr[%0d]: got %0d/%0d expected %0d", i,
                                       trace_q[160 + 2*i].a, trace_q[161 + 2*i].a, int'(N) - 1 - i);
                end
            end
            checks++;
            if (trace_q[224].a !== AW'(int'(N) - 1)) begin
                errors++; $display("FAIL m4_start_addr: got %0d expected %0d", trace_q[224].a, N - 1);
            end
        end
    endtask

    task automatic test_stuck0();
        int nb; acc_t ex;
        fault_en = 1'b1; fault_addr = AW'(7); sa0_mask = 32'h0000_0008; sa1_mask = '0;
        build_expected();
        run_march(-1, -1, nb);
        for (int k = 0; k < obs_q.size(); k++) begin
            ex = exp_q.pop_front();
            checks++;
            if (obs_q[k] !== ex) begin errors++; $display("FAIL sa0_access[%0d]: got %h expected %h", k, obs_q[k], ex); end
        end
        // Failing r1 of M2 at addr 7 is busy cycle 110; busy ends after the compare cycle.
        checks++; if (nb != 112) begin errors++; $display("FAIL sa0_busy_cycles: got %0d expected 112", nb); end
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL sa0_fail: got %b expected 1", fail); end
        checks++; if (fail_elem !== 3'd2) begin errors++; $display("FAIL sa0_elem: got %0d expected 2", fail_elem); end
        checks++; if (fail_addr !== AW'(7)) begin errors++; $display("FAIL sa0_addr: got %0d expected 7", fail_addr); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sa0_done: got %b expected 1", done); end
        fault_en = 1'b0;
    endtask

    task automatic test_rerun_from_done();
        int nb; acc_t ex;
        build_expected();
        run_march(-1, -1, nb);
        checks++; if (first_done !== 1'b0 || first_fail !== 1'b0) begin
            errors++; $display("FAIL rerun_clear: got done %b fail %b expected 0 0", first_done, first_fail);
        end
        checks++; if (first_faddr !== '0 || first_felem !== '0) begin
            errors++; $display("FAIL rerun_clear_info: got addr %0d elem %0d expected 0 0", first_faddr, first_felem);
        end
        for (int k = 0; k < obs_q.size(); k++) begin
            ex = exp_q.pop_front();
            checks++;
            if (obs_q[k] !== ex) begin errors++; $display("FAIL rerun_access[%0d]: got %h expected %h", k, obs_q[k], ex); end
        end
        checks++; if (nb != 321) begin errors++; $display("FAIL rerun_busy_cycles: got %0d expected 321", nb); end
        checks++; if (done !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL rerun_result: got done %b fail %b expected 1 0", done, fail);
        end
    endtask

    task automatic test_stuck1();
        int nb;
        fault_en = 1'b1; fault_addr = '0; sa0_mask = '0; sa1_mask = 32'h0000_0001;
        build_expected();
        run_march(-1, -1, nb);
        checks++; if (nb != 34) begin errors++; $display("FAIL sa1_busy_cycles: got %0d expected 34", nb); end
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL sa1_fail: got %b expected 1", fail); end
        checks++; if (fail_elem !== 3'd1) begin errors++; $display("FAIL sa1_elem: got %0d expected 1", fail_elem); end
        checks++; if (fail_addr !== '0) begin errors++; $display("FAIL sa1_addr: got %0d expected 0", fail_addr); end
        fault_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_start_while_busy();
        int nb; acc_t ex;
        build_expected();
        run_march(50, -1, nb);
        for (int k = 0; k < obs_q.size(); k++) begin
            ex = exp_q.pop_front();
            checks++;
            if (obs_q[k] !== ex) begin errors++; $display("FAIL busy_start_access[%0d]: got %h expected %h", k, obs_q[k], ex); end
        end
        checks++; if (nb != 321) begin errors++; $display("FAIL busy_start_cycles: got %0d expected 321", nb); end
        checks++; if (done !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL busy_start_result: got done %b fail %b expected 1 0", done, fail);
        end
    endtask

    task automatic test_rst_mid();
        int nb;
        build_expected();
        run_march(-1, 100, nb);
        checks++; if (nb != 101) begin errors++; $display("FAIL rst_mid_cycles: got %0d expected 101", nb); end
        checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", post_busy); end
        checks++; if (post_acc !== idle_acc) begin errors++; $display("FAIL rst_mid_ports: got %h expected %h", post_acc, idle_acc); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: got done %b busy %b expected 0 0", done, busy);
        end
        build_expected();
        run_march(-1, -1, nb);
        checks++; if (nb != 321) begin errors++; $display("FAIL rst_rerun_cycles: got %0d expected 321", nb); end
        checks++; if (done !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL rst_rerun_result: got done %b fail %b expected 1 0", done, fail);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) mem[i] = 32'hA5C3_5A3C ^ DW'(i);
        idle_acc = '{bist: 1'b0, csn: 1'b1, wen: 1'b1, a: '0, d: '0, be: '0};
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_fault_free();
        test_m3_trace();
        test_stuck0();
        test_rerun_from_done();
        test_stuck1();
        test_start_while_busy();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scm_bist_ctrl.md
SCM_BIST_CTRL -- requirements
Module: scm_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, address width of the SCM under test.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of the SCM under test.
REQ-003 SHALL have parameter NUM_BYTE, default DATA_WIDTH/8, number of byte enables.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a test.
REQ-007 SHALL have port busy  output  1  high while a test runs.
REQ-008 SHALL have port done  output  1  sticky test-complete flag.
REQ-009 SHALL have port fail  output  1  sticky mismatch flag.
REQ-010 SHALL have port fail_addr  output  ADDR_WIDTH  address of the first mismatch.
REQ-011 SHALL have port fail_elem  output  3  march element of the first mismatch.
REQ-012 SHALL have port BIST  output  1  test-port select for the SCM wrapper.
REQ-013 SHALL have ports CSN_T, WEN_T (out, 1), A_T (out, ADDR_WIDTH), D_T (out, DATA_WIDTH), BE_T (out, NUM_BYTE) and Q_T (in, DATA_WIDTH), with SRAM-style test-port semantics: CSN_T=0 & WEN_T=0 writes, CSN_T=0 & WEN_T=1 reads.

Function
REQ-014 SHALL run March C- over N=2**ADDR_WIDTH words: M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 up r0.
REQ-015 SHALL use 0 = all-zero word and 1 = all-ones word, with BE_T all ones for every write.
REQ-016 SHALL issue exactly one SCM access per cycle; an rX,wY pair SHALL be a read cycle followed by a write cycle to the same address.
REQ-017 SHALL treat Q_T as valid in the cycle after a read cycle and compare it with the expected word in that cycle.
REQ-018 SHALL have states IDLE -> RUN (element counter 0..5, phase bit rd/wr) -> FLUSH (final M5 compare) -> DONE -> IDLE on start.
REQ-019 SHALL count "up" as 0..N-1 and "down" as N-1..0, then wrap to the next element's start address without an idle cycle.
REQ-020 SHALL keep busy high for exactly 10*N+1 cycles on a fault-free run, starting the cycle after start is sampled in IDLE or DONE.
REQ-021 SHALL, on the first mismatch, set fail, capture fail_addr/fail_elem, and abort to DONE in the next cycle.
REQ-022 SHALL hold done high in DONE until the next accepted start; that start SHALL clear done, fail, fail_addr and fail_elem.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL drive BIST=1 only while busy; otherwise BIST=0, CSN_T=1, WEN_T=1, A_T=0, D_T=0, BE_T=0.

Reset
REQ-025 SHALL, on rst, go to IDLE in the next cycle with busy=done=fail=0, fail_addr=0, fail_elem=0, and test ports at the REQ-024 idle values.
REQ-026 SHALL discard a run interrupted by rst; only a new start restarts testing.

Structure
REQ-027 SHALL have package scm_bist_pkg containing the state enum, the march element enum (M0..M5), NUM_ELEM=6, and the per-element direction/read-value/write-value table.
REQ-028 SHALL have one sub-module scm_bist_addr_gen: an up/down address counter with load, enable and last-address flag.

Verification (ADDR_WIDTH=5, N=32, behavioural 1r1w SCM model with 1-cycle read)
REQ-029 SHALL check: fault-free model, start pulse -> busy for 321 cycles, then done=1, fail=0.
REQ-030 SHALL check: addr 7, bit 3 stuck-at-0 -> fail=1, fail_elem=2, fail_addr=7, busy drops the cycle after the mismatch.
REQ-031 SHALL check: addr 0, bit 0 stuck-at-1 -> fail=1, fail_elem=1, fail_addr=0.
REQ-032 SHALL check: rst at busy cycle 100 -> next cycle BIST=0, CSN_T=1, busy=0; a new start then completes in 321 cycles with fail=0.
REQ-033 SHALL check: start pulsed while busy -> no effect and total still 321 cycles; start in DONE -> done and fail clear and the test reruns.
REQ-034 SHALL check: address trace during M3 runs 31 down to 0 and M4 starts at 31 in the following cycle.
